// File: rtl/sub_pkg.sv
// sub_pkg: widths, word types, saturation limits and carry-lookahead helpers for the pipelined subtractor
package sub_pkg;
    localparam int WIDTH = 32;
    localparam int LO_W  = 16;
    typedef logic [WIDTH-1:0] word_t;
    typedef logic [LO_W-1:0]  half_t;
    localparam word_t SAT_POS = 32'h7FFF_FFFF;
    localparam word_t SAT_NEG = 32'h8000_0000;
    // group generate of a 4-bit block
    function automatic logic gen4(input logic [3:0] g, input logic [3:0] p);
        return g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0];
    endfunction
    // carries into bits 0..3 of a 4-bit block, fully expanded from ci
    function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        return {g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & ci,
                g[1] | p[1] & g[0] | p[1] & p[0] & ci,
                g[0] | p[0] & ci,
                ci};
    endfunction
endpackage

// File: rtl/sub_half_16.sv
// sub_half_16: combinational 16-bit a + ~b + cin slice with two-level carry-lookahead
module sub_half_16
    import sub_pkg::*;
(
    input  logic  [LO_W-1:0] a,
    input  logic  [LO_W-1:0] b,
    input  logic             cin,
    output logic  [LO_W-1:0] d,
    output logic             cout
);
    half_t g, p, c;
    logic [3:0] gg, pg, gc;
    assign g = a & ~b;
    assign p = a ^ ~b;
    for (genvar i = 0; i < 4; i++) begin : grp
        assign gg[i] = gen4(g[4*i+:4], p[4*i+:4]);
        assign pg[i] = &p[4*i+:4];
        assign c[4*i+:4] = cla4(g[4*i+:4], p[4*i+:4], gc[i]);
    end
    assign gc = cla4(gg, pg, cin);
    assign cout = gen4(gg, pg) | &pg & cin;
    assign d = p ^ c;
endmodule

// File: rtl/subtractor_32bit_pipe.sv
// subtractor_32bit_pipe: two-stage D = A - B - BIN with borrow/overflow flags behind valid/ready.
// Define SUB_SATURATE_EN to clamp D to the signed limits on overflow.
module subtractor_32bit_pipe
    import sub_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             BOUT,
    output logic             OVF
);
    half_t d_lo, a_hi, b_hi, lo_d, hi_d;
    logic s1_valid, c16, lo_c, hi_c, adv2, ovf;
    word_t d_nxt;
    assign adv2 = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | adv2;
    sub_half_16 u_lo (.a(A[LO_W-1:0]), .b(B[LO_W-1:0]), .cin(~BIN), .d(lo_d), .cout(lo_c));
    sub_half_16 u_hi (.a(a_hi), .b(b_hi), .cin(c16), .d(hi_d), .cout(hi_c));
    assign ovf = (a_hi[LO_W-1] ^ b_hi[LO_W-1]) & (a_hi[LO_W-1] ^ hi_d[LO_W-1]);
`ifdef SUB_SATURATE_EN
    assign d_nxt = ovf ? (a_hi[LO_W-1] ? SAT_NEG : SAT_POS) : {hi_d, d_lo};
`else
    assign d_nxt = {hi_d, d_lo};
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1_valid <= 1'b0;
            d_lo     <= '0;
            c16      <= 1'b0;
            a_hi     <= '0;
            b_hi     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                d_lo <= lo_d;
                c16  <= lo_c;
                a_hi <= A[WIDTH-1:LO_W];
                b_hi <= B[WIDTH-1:LO_W];
            end
        end
    // result registers only move when downstream can take them, so D is stable under stall
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid <= 1'b0;
            D         <= '0;
            BOUT      <= 1'b0;
            OVF       <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                D    <= d_nxt;
                BOUT <= ~hi_c;
                OVF  <= ovf;
            end
        end
endmodule

// File: doc/subtractor_32bit_pipe.md
Name: subtractor_32bit_pipe

Overview:
- Two-stage pipelined 32-bit subtractor: D = A - B - BIN, with borrow-out and signed-overflow flags.
- Low 16 bits are resolved in stage 1; the inter-half carry is registered; high 16 bits are resolved in stage 2.
- Companion to the 32-bit CLA adder datapath. Sits on the arithmetic path behind a valid/ready handshake, so upstream and downstream can stall independently.

Parameters:
- WIDTH, 32, operand/result width. Fixed at 32; other values unsupported.
- LO_W, 16, width of the stage-1 (low) slice. Stage 2 handles WIDTH-LO_W bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block accepts operands this cycle.
- A  input  32  minuend.
- B  input  32  subtrahend.
- BIN  input  1  borrow in.
- out_valid  output  1  result presented.
- out_ready  input  1  downstream accepts result.
- D  output  32  difference, modulo 2^32.
- BOUT  output  1  unsigned borrow out (A < B + BIN).
- OVF  output  1  signed two's-complement overflow.

Behaviour:
- Arithmetic: A + ~B + ~BIN.
  - Stage 1: D[16:1] = A[16:1] + ~B[16:1] + ~BIN, producing carry c16.
  - Stage 2: D[32:17] = A[32:17] + ~B[32:17] + c16, producing carry c32.
  - BOUT = ~c32.
  - OVF = (A[32] ^ B[32]) & (A[32] ^ D[32]).
- Stage-1 registers: s1_valid, D_lo, c16, A[32:17], B[32:17].
- Stage-2 registers: out_valid, D, BOUT, OVF. Outputs are driven directly from these registers.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - adv2 = ~out_valid | out_ready.
  - in_ready = ~s1_valid | adv2 (combinational; no dependence on in_valid).
- Latency and throughput: 2 cycles from the accepting edge to out_valid; 1 transaction per cycle sustained with out_ready held high.
- Stall: when out_ready=0 and out_valid=1, D/BOUT/OVF must remain stable. Stage 1 holds if occupied. The pipeline buffers at most 2 transactions, and order is preserved.
- Simultaneous events: when stage 2 drains and stage 1 is refilled in the same cycle, both occur; no bubble is inserted.
- Data capture: operands are sampled only on an input transfer. A, B and BIN are don't-care otherwise.
- Reset:
  - rst_n low clears s1_valid, out_valid, D, BOUT and OVF to 0 immediately (asynchronous).
  - Data registers also clear to 0.
  - Reset mid-operation drops in-flight transactions silently. The first acceptance is possible on the first clk edge after rst_n deasserts.
- Wrap-around: D wraps modulo 2^32; BOUT and OVF report the event.

Optional Feature:
- Macro: SUB_SATURATE_EN.
- Defined: when OVF=1, D clamps to 0x7FFF_FFFF if A[32]=0, or to 0x8000_0000 if A[32]=1. The clamp is applied in stage 2 before the output register. OVF and BOUT are unchanged, and latency is unchanged.
- Undefined: D wraps modulo 2^32.

Decomposition:
- Package sub_pkg:
  - constants WIDTH=32 and LO_W=16;
  - typedef word_t (32-bit) and half_t (16-bit);
  - SAT_POS=32'h7FFF_FFFF and SAT_NEG=32'h8000_0000.
- Sub-module sub_half_16: combinational 16-bit slice (a, b, cin -> d, cout) computing a + ~b + cin with internal carry-lookahead. Instantiated once per stage.

Test Plan:
- A=5, B=3, BIN=0, out_ready=1 -> 2 cycles later: D=0x0000_0002, BOUT=0, OVF=0.
- A=0, B=1, BIN=0 -> D=0xFFFF_FFFF, BOUT=1, OVF=0. A=7, B=7, BIN=1 -> D=0xFFFF_FFFF, BOUT=1.
- A=0x0001_0000, B=1 -> D=0x0000_FFFF, BOUT=0. This checks the c16 borrow across the pipeline split.
- A=0x8000_0000, B=1 -> OVF=1, BOUT=0, D=0x7FFF_FFFF. With SUB_SATURATE_EN: D=0x8000_0000. A=0x7FFF_FFFF, B=0xFFFF_FFFF -> OVF=1, saturated D=0x7FFF_FFFF.
- Backpressure: hold out_ready=0 and offer 3 back-to-back operations.
  - Exactly 2 are accepted, then in_ready=0.
  - D stays stable while stalled.
  - After out_ready=1, results emerge in order with no loss or duplication.
  - Continuous stream with out_ready=1 -> one result per cycle.
- Assert rst_n=0 while both stages hold valid data -> out_valid=0 and D=0 before the next clk edge. After release, the first new input produces a correct result 2 cycles after acceptance.
